// File: rtl/conv_frame_encoder.sv
// Collects a 4-byte frame, rate-1/2 convolutionally encodes its 32 bits (K=3),
// and hands the 8 resulting bytes to a byte-wide transmitter one at a time.
`timescale 1ns / 1ps
module conv_frame_encoder #(
  parameter logic [2:0] G0 = 3'b111,
  parameter logic [2:0] G1 = 3'b101
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       flush,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       in_ready,
  output logic       frame_done,
  output logic       rx_dropped
);

  typedef enum logic [1:0] {StCollect, StEncode, StSendStart, StSendHold} state_e;

  state_e      state_q, state_d;
  logic [1:0]  k_q, k_d;
  logic [4:0]  bit_q, bit_d;
  logic [2:0]  j_q, j_d;
  logic        s1_q, s1_d, s0_q, s0_d;
  logic [31:0] frame_q, frame_d;
  logic [63:0] enc_q, enc_d;
  logic        seen_busy_q, seen_busy_d;
  logic        tx_start_q, tx_start_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        frame_done_q, frame_done_d;
  logic        rx_dropped_q, rx_dropped_d;

  logic cur_bit, out0, out1;

  // Tap order within a generator: {current bit, x[n-1], x[n-2]}.
  assign cur_bit = frame_q[bit_q];
  assign out0    = ^(G0 & {cur_bit, s1_q, s0_q});
  assign out1    = ^(G1 & {cur_bit, s1_q, s0_q});

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    bit_d        = bit_q;
    j_d          = j_q;
    s1_d         = s1_q;
    s0_d         = s0_q;
    frame_d      = frame_q;
    enc_d        = enc_q;
    seen_busy_d  = seen_busy_q;
    tx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    frame_done_d = 1'b0;
    rx_dropped_d = rx_dropped_q;

    if (flush) begin
      state_d      = StCollect;
      k_d          = 2'd0;
      bit_d        = 5'd0;
      j_d          = 3'd0;
      s1_d         = 1'b0;
      s0_d         = 1'b0;
      seen_busy_d  = 1'b0;
      rx_dropped_d = 1'b0;
    end else begin
      if (rx_valid && (state_q != StCollect)) begin
        rx_dropped_d = 1'b1;
      end
      unique case (state_q)
        StCollect: begin
          if (rx_valid) begin
            frame_d[{k_q, 3'b000} +: 8] = rx_data;
            k_d = k_q + 2'd1;
            if (k_q == 2'd3) begin
              state_d = StEncode;
              k_d     = 2'd0;
              bit_d   = 5'd0;
              s1_d    = 1'b0;
              s0_d    = 1'b0;
            end
          end
        end
        StEncode: begin
          enc_d[{bit_q, 1'b0} +: 2] = {out1, out0};
          s0_d  = s1_q;
          s1_d  = cur_bit;
          bit_d = bit_q + 5'd1;
          if (bit_q == 5'd31) begin
            state_d = StSendStart;
            j_d     = 3'd0;
          end
        end
        StSendStart: begin
          if (!tx_busy) begin
            tx_start_d  = 1'b1;
            tx_data_d   = enc_q[{j_q, 3'b000} +: 8];
            seen_busy_d = 1'b0;
            state_d     = StSendHold;
          end
        end
        StSendHold: begin
          // The transmitter raises busy a little after tx_start; wait for the full busy window.
          if (!seen_busy_q) begin
            if (tx_busy) seen_busy_d = 1'b1;
          end else if (!tx_busy) begin
            if (j_q == 3'd7) begin
              frame_done_d = 1'b1;
              state_d      = StCollect;
              j_d          = 3'd0;
            end else begin
              j_d     = j_q + 3'd1;
              state_d = StSendStart;
            end
          end
        end
        default: state_d = StCollect;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StCollect;
      k_q          <= 2'd0;
      bit_q        <= 5'd0;
      j_q          <= 3'd0;
      s1_q         <= 1'b0;
      s0_q         <= 1'b0;
      frame_q      <= 32'd0;
      enc_q        <= 64'd0;
      seen_busy_q  <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_data_q    <= 8'h00;
      frame_done_q <= 1'b0;
      rx_dropped_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      bit_q        <= bit_d;
      j_q          <= j_d;
      s1_q         <= s1_d;
      s0_q         <= s0_d;
      frame_q      <= frame_d;
      enc_q        <= enc_d;
      seen_busy_q  <= seen_busy_d;
      tx_start_q   <= tx_start_d;
      tx_data_q    <= tx_data_d;
      frame_done_q <= frame_done_d;
      rx_dropped_q <= rx_dropped_d;
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign in_ready   = (state_q == StCollect);
  assign frame_done = frame_done_q;
  assign rx_dropped = rx_dropped_q;

endmodule

// File: tb/tb_conv_frame_encoder.sv
// Directed bench for conv_frame_encoder: a frame-level encoder model feeds an expected-byte
// queue that a negedge checker compares against every tx_start, alongside a simple transmitter.
`timescale 1ns / 1ps
module tb_conv_frame_encoder;

  localparam logic [2:0] TbG0 = 3'b111;
  localparam logic [2:0] TbG1 = 3'b101;
  localparam int TxLen = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       flush = 1'b0;
  logic       tx_busy = 1'b0;
  logic       tx_start, in_ready, frame_done, rx_dropped;
  logic [7:0] tx_data;

  int vectors = 0;
  int miscompares = 0;
  int tx_start_count = 0;
  int frames_done = 0;
  int sent_in_frame = 0;
  int busy_cnt = 0;
  bit hold_busy = 1'b0;
  bit stab_en = 1'b0;
  logic [7:0] last_tx = 8'h00;
  logic [7:0] exp_q[$];

  conv_frame_encoder #(.G0(TbG0), .G1(TbG1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .flush     (flush),
    .tx_busy   (tx_busy),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .in_ready  (in_ready),
    .frame_done(frame_done),
    .rx_dropped(rx_dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame-level model: each output pair depends on the bit and its two predecessors in the frame.
  function automatic logic [63:0] encode(input logic [31:0] f);
    logic [63:0] e;
    logic p1, p2;
    e = '0;
    for (int i = 0; i < 32; i++) begin
      p1 = (i >= 1) ? f[i-1] : 1'b0;
      p2 = (i >= 2) ? f[i-2] : 1'b0;
      e[2*i]   = ^(TbG0 & {f[i], p1, p2});
      e[2*i+1] = ^(TbG1 & {f[i], p1, p2});
    end
    return e;
  endfunction

  // Checker plus transmitter model; both live in one process so tx_busy ordering is fixed.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (rst_n) begin
      if (tx_start) begin
        tx_start_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_tx_start", 64'(tx_data), 64'hxx);
        end else begin
          exp_b = exp_q.pop_front();
          check("tx_data", 64'(tx_data), 64'(exp_b));
        end
        last_tx = tx_data;
        busy_cnt = TxLen;
        stab_en = 1'b1;
        sent_in_frame++;
      end else if (busy_cnt > 0) begin
        if (stab_en) check("tx_data_stable", 64'(tx_data), 64'(last_tx));
        busy_cnt--;
      end
      if (frame_done) begin
        check("bytes_per_frame", 64'(sent_in_frame), 64'd8);
        sent_in_frame = 0;
        frames_done++;
      end
    end
    tx_busy = hold_busy || (busy_cnt != 0);
  end

  task automatic send_byte(input logic [7:0] d);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = d;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_flush();
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] f, input bit measure);
    logic [63:0] e;
    int n;
    e = encode(f);
    for (int j = 0; j < 8; j++) exp_q.push_back(e[8*j +: 8]);
    for (int b = 0; b < 4; b++) send_byte(f[8*b +: 8]);
    if (measure) begin
      n = 0;
      for (int c = 1; c <= 60; c++) begin
        @(posedge clk); #1;
        if (tx_start) begin
          n = c;
          break;
        end
      end
      check("first_tx_latency", 64'(n), 64'd33);
    end
  endtask

  task automatic wait_frame(input string name);
    int start;
    start = frames_done;
    for (int c = 0; c < 3000 && frames_done == start; c++) @(posedge clk);
    check({name, "_frame_done"}, 64'(frames_done - start), 64'd1);
    check({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
    #1;
  endtask

  task automatic wait_starts(input int target);
    for (int c = 0; c < 1000 && tx_start_count < target; c++) @(posedge clk);
    check("tx_start_wait", 64'(tx_start_count >= target), 64'd1);
  endtask

  initial begin
    logic [63:0] e;
    logic [7:0]  txd0;
    int base;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_tx_start", 64'(tx_start), 64'd0);
    check("rst_tx_data", 64'(tx_data), 64'h00);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    check("rst_rx_dropped", 64'(rx_dropped), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Hand-derived values that pin the model.
    e = encode(32'h0000_0001);
    check("model_pin_37", e[7:0], 64'h37);
    check("model_pin_01_rest", e[63:8], 64'h0);
    e = encode(32'hFFFF_FFFF);
    check("model_pin_5b", e[7:0], 64'h5B);
    check("model_pin_55", e[15:8], 64'h55);
    check("model_pin_55_last", e[63:56], 64'h55);

    send_frame(32'h0000_0001, 1'b1);
    wait_frame("f01");
    send_frame(32'hFFFF_FFFF, 1'b1);
    wait_frame("fff");
    send_frame(32'h0000_0000, 1'b0);
    wait_frame("f00");
    send_frame(32'h0000_0001, 1'b1);
    wait_frame("f01_again");

    // Transmitter held busy across the whole SEND_START window.
    send_frame(32'h0403_0201, 1'b0);
    hold_busy = 1'b1;
    base = tx_start_count;
    txd0 = tx_data;
    repeat (133) @(posedge clk);
    #1;
    check("hold_no_start", 64'(tx_start_count - base), 64'd0);
    check("hold_tx_data", 64'(tx_data), 64'(txd0));
    hold_busy = 1'b0;
    wait_frame("hold");

    // Partial frame discarded by flush.
    send_byte(8'h11);
    send_byte(8'h22);
    do_flush();
    check("flush_in_ready", 64'(in_ready), 64'd1);
    send_frame(32'h0000_0001, 1'b1);
    wait_frame("after_partial");

    // Flush while a byte is in flight.
    base = tx_start_count;
    send_frame(32'hFFFF_FFFF, 1'b0);
    wait_starts(base + 3);
    do_flush();
    exp_q.delete();
    sent_in_frame = 0;
    stab_en = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("flush_send_no_start", 64'(tx_start_count - base), 64'd3);
    check("flush_send_in_ready", 64'(in_ready), 64'd1);

    // Byte during ENCODE is dropped, then async reset mid-send.
    base = tx_start_count;
    send_frame(32'hC33C_A55A, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rx_valid = 1'b1;
    rx_data  = 8'hAA;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    check("drop_rx_dropped", 64'(rx_dropped), 64'd1);
    check("drop_in_ready", 64'(in_ready), 64'd0);
    wait_starts(base + 2);
    @(posedge clk); #3;
    rst_n = 1'b0;
    exp_q.delete();
    sent_in_frame = 0;
    stab_en = 1'b0;
    #1;
    check("arst_tx_start", 64'(tx_start), 64'd0);
    check("arst_tx_data", 64'(tx_data), 64'h00);
    check("arst_frame_done", 64'(frame_done), 64'd0);
    check("arst_rx_dropped", 64'(rx_dropped), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = tx_start_count;
    repeat (50) @(posedge clk);
    #1;
    check("arst_no_spurious_start", 64'(tx_start_count - base), 64'd0);
    send_frame(32'h0000_0001, 1'b1);
    wait_frame("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/conv_frame_encoder.md
CONV_FRAME_ENCODER -- requirements
Module: conv_frame_encoder

Interface
REQ-001 SHALL have parameter G0, default 3'b111, generator polynomial for output bit 0 (taps: current bit, x[n-1], x[n-2]).
REQ-002 SHALL have parameter G1, default 3'b101, generator polynomial for output bit 1.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port rx_valid  input  1  one-cycle strobe: rx_data is a received byte (from async_receiver).
REQ-006 SHALL have port rx_data  input  8  received byte.
REQ-007 SHALL have port flush  input  1  debounced abort; discards any partial or in-flight frame.
REQ-008 SHALL have port tx_busy  input  1  transmitter busy (from async_transmitter).
REQ-009 SHALL have port tx_start  output  1  one-cycle request to transmit tx_data.
REQ-010 SHALL have port tx_data  output  8  encoded byte to transmit.
REQ-011 SHALL have port in_ready  output  1  high only in COLLECT.
REQ-012 SHALL have port frame_done  output  1  one-cycle pulse after the 8th encoded byte completes.
REQ-013 SHALL have port rx_dropped  output  1  sticky: a byte arrived while in_ready was low.

Function
REQ-014 SHALL implement states COLLECT, ENCODE, SEND_START, SEND_HOLD.
REQ-015 COLLECT: each rx_valid SHALL store rx_data into frame byte k (k=0..3, byte 0 = bits 7:0 of the 32-bit frame) and increment k.
REQ-016 On acceptance of byte 3, next state SHALL be ENCODE, with k cleared and encoder shift state (s1,s0) cleared to 00.
REQ-017 ENCODE SHALL process one frame bit per cycle, bit i = 0..31 in ascending order, exactly 32 cycles.
REQ-018 For bit b: out0 = XOR of taps of G0 over (b,s1,s0), out1 = XOR of taps of G1 over (b,s1,s0); then s0<=s1, s1<=b.
REQ-019 Defaults yield out0 = b^s1^s0, out1 = b^s0; enc[2i] = out0, enc[2i+1] = out1 in a 64-bit register.
REQ-020 After bit 31, next state SHALL be SEND_START with byte index j=0.
REQ-021 SEND_START: when tx_busy=0, SHALL assert tx_start for exactly one cycle with tx_data = enc[8j+7:8j], then go to SEND_HOLD; when tx_busy=1, SHALL wait.
REQ-022 tx_data SHALL remain stable from the tx_start cycle until the byte completes.
REQ-023 SEND_HOLD: SHALL first wait for tx_busy=1, then for tx_busy=0; then j<7 -> j+1 and SEND_START; j=7 -> pulse frame_done, go to COLLECT.
REQ-024 First tx_start SHALL occur 33 clk edges after the edge that accepts byte 3, given tx_busy=0.
REQ-025 rx_valid outside COLLECT SHALL be ignored (no state or frame change) and SHALL set rx_dropped.
REQ-026 flush SHALL, in any state and on the next edge: go to COLLECT, clear k, j, s1, s0, and tx_start; clear rx_dropped; leave the frame and enc registers contents undefined.
REQ-027 flush and rx_valid in the same cycle: flush wins and the byte is discarded.
REQ-028 A flush during SEND_HOLD SHALL NOT wait for tx_busy; a byte already started in the transmitter completes on its own.
REQ-029 Encoder state SHALL NOT carry across frames; every frame starts from s1=s0=0 and has no tail bits.

Reset
REQ-030 With rst_n=0, SHALL hold state COLLECT, k=j=0, s1=s0=0, tx_start=0, tx_data=8'h00, frame_done=0, rx_dropped=0, in_ready=1, frame and enc registers cleared to 0.
REQ-031 rst_n assertion mid-ENCODE or mid-SEND SHALL abort immediately (asynchronously); after deassertion, operation SHALL resume in COLLECT with no spurious tx_start.

Verification
REQ-032 Send bytes 01,00,00,00 with tx_busy modelled -> exactly 8 tx_start pulses carrying 37,00,00,00,00,00,00,00, then one frame_done pulse.
REQ-033 Send FF,FF,FF,FF -> bytes sent 5B,55,55,55,55,55,55,55; first tx_start 33 edges after byte 3 is accepted.
REQ-034 Send 00 x4 -> eight 00 bytes; then send frame 01,00,00,00 -> output 37 first, proving no state carries over between frames.
REQ-035 Hold tx_busy=1 for 100 cycles at SEND_START -> tx_start stays 0 until tx_busy falls, and tx_data stays stable.
REQ-036 Send 2 bytes, then flush, then 01,00,00,00 -> output 37,00..00 (the partial frame is discarded); flush mid-SEND -> no further tx_start and in_ready=1.
REQ-037 Send rx_valid during ENCODE -> rx_dropped=1 and output unchanged; pulse rst_n low mid-SEND -> all outputs return to their reset values at once.
